// File: rtl/fir_channel_scheduler_pkg.sv
// Shared state encoding and datapath strobe layout for the multi-channel FIR scheduler.
// Also consumed by the datapath bench.
package fir_sched_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MAC  = 3'd2,
        DONE = 3'd3,
        OUT  = 3'd4
    } sched_state_t;

    localparam int unsigned DP_LOAD_BIT    = 0;
    localparam int unsigned DP_CLR_BIT     = 1;
    localparam int unsigned DP_CNT_BIT     = 2;
    localparam int unsigned DP_LOADRES_BIT = 3;
    localparam int unsigned DP_NSTROBES    = 4;

    typedef logic [DP_NSTROBES-1:0] dp_strobe_t;

    function automatic dp_strobe_t dp_strobes(input sched_state_t s);
        dp_strobe_t st;
        st = '0;
        case (s)
            LOAD: begin
                st[DP_LOAD_BIT] = 1'b1;
                st[DP_CLR_BIT]  = 1'b1;
            end
            MAC:     st[DP_CNT_BIT]     = 1'b1;
            DONE:    st[DP_LOADRES_BIT] = 1'b1;
            default: st = '0;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/fir_channel_scheduler_rr_arbiter.sv
// Request arbiter for the FIR channel scheduler: one-hot grant plus encoded index.
// FIR_SCHED_FIXED_PRIO_EN selects lowest-index-wins and drops the pointer input.
module rr_arbiter
    import fir_sched_pkg::*;
#(
    parameter int unsigned NCH    = 4,
    parameter int unsigned LOGNCH = 2
) (
    input  logic [NCH-1:0]    req,
`ifndef FIR_SCHED_FIXED_PRIO_EN
    input  logic [LOGNCH-1:0] ptr,
`endif
    output logic [NCH-1:0]    grant,
    output logic [LOGNCH-1:0] grant_idx,
    output logic              grant_any
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
`ifdef FIR_SCHED_FIXED_PRIO_EN
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!grant_any && req[i]) begin
                grant[i]  = 1'b1;
                grant_idx = LOGNCH'(i);
                grant_any = 1'b1;
            end
        end
`else
        // Two ascending passes: indices at/after the pointer first, then the wrapped ones.
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!grant_any && req[i] && (i >= 32'(ptr))) begin
                grant[i]  = 1'b1;
                grant_idx = LOGNCH'(i);
                grant_any = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!grant_any && req[i] && (i < 32'(ptr))) begin
                grant[i]  = 1'b1;
                grant_idx = LOGNCH'(i);
                grant_any = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/fir_channel_scheduler.sv
// Shares one FIR MAC datapath across NCH channels: grant, load, clear, tap sweep, latch, output.
// Define FIR_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module fir_channel_scheduler
    import fir_sched_pkg::*;
#(
    parameter int unsigned INWIDTH    = 16,
    parameter int unsigned NCH        = 4,
    parameter int unsigned LOGNCH     = 2,
    parameter int unsigned COEFNUM    = 64,
    parameter int unsigned LOGCOEFNUM = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NCH-1:0]         ch_valid,
    input  logic [NCH*INWIDTH-1:0] ch_data,
    output logic [NCH-1:0]         ch_ready,
    output logic [INWIDTH-1:0]     dp_sample,
    output logic [LOGNCH-1:0]      dp_bank,
    output logic                   dp_load,
    output logic                   dp_clr_res,
    output logic                   dp_cnt_en,
    output logic [LOGCOEFNUM-1:0]  dp_coef_addr,
    output logic                   dp_loadres,
    output logic                   out_valid,
    output logic [LOGNCH-1:0]      out_ch,
    input  logic                   out_ready,
    output logic                   busy
);

    sched_state_t          state, state_next;
    logic [LOGCOEFNUM-1:0] cnt, cnt_next;
    dp_strobe_t            strobe_q;
    logic [NCH-1:0]        grant;
    logic [LOGNCH-1:0]     grant_idx;
    logic                  grant_any;
    logic                  accept;
`ifndef FIR_SCHED_FIXED_PRIO_EN
    logic [LOGNCH-1:0]     ptr;
`endif

    rr_arbiter #(
        .NCH    (NCH),
        .LOGNCH (LOGNCH)
    ) u_arb (
        .req       (ch_valid),
`ifndef FIR_SCHED_FIXED_PRIO_EN
        .ptr       (ptr),
`endif
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Grant is a subset of ch_valid, so any grant in IDLE is a completed handshake.
    assign accept   = (state == IDLE) && grant_any;
    assign ch_ready = ((state == IDLE) && reset) ? grant : '0;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: if (accept) state_next = LOAD;
            LOAD: begin
                cnt_next   = '0;
                state_next = MAC;
            end
            MAC: begin
                if (cnt == LOGCOEFNUM'(COEFNUM - 1)) state_next = DONE;
                else                                 cnt_next   = cnt + 1'b1;
            end
            DONE: state_next = OUT;
            OUT:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            strobe_q     <= '0;
            dp_coef_addr <= '0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            dp_sample    <= '0;
            dp_bank      <= '0;
            out_ch       <= '0;
`ifndef FIR_SCHED_FIXED_PRIO_EN
            ptr          <= '0;
`endif
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            // Strobes are decoded from the next state so they are flops aligned with state.
            strobe_q     <= dp_strobes(state_next);
            dp_coef_addr <= (state_next == MAC) ? cnt_next : '0;
            out_valid    <= (state_next == OUT);
            busy         <= (state_next != IDLE);
            if (accept) begin
                dp_sample <= ch_data[32'(grant_idx)*INWIDTH +: INWIDTH];
                dp_bank   <= grant_idx;
                out_ch    <= grant_idx;
`ifndef FIR_SCHED_FIXED_PRIO_EN
                ptr       <= (grant_idx == LOGNCH'(NCH - 1)) ? '0 : grant_idx + 1'b1;
`endif
            end
        end
    end

    assign dp_load    = strobe_q[DP_LOAD_BIT];
    assign dp_clr_res = strobe_q[DP_CLR_BIT];
    assign dp_cnt_en  = strobe_q[DP_CNT_BIT];
    assign dp_loadres = strobe_q[DP_LOADRES_BIT];

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Self-checking bench for fir_channel_scheduler: per-cycle timeline model plus directed literal checks.
module tb_fir_channel_scheduler;

    localparam int INWIDTH    = 16;
    localparam int NCH        = 4;
    localparam int LOGNCH     = 2;
    localparam int COEFNUM    = 64;
    localparam int LOGCOEFNUM = 6;
    localparam int T_OUT      = COEFNUM + 3;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [NCH-1:0]         ch_valid;
    logic [NCH*INWIDTH-1:0] ch_data;
    logic [NCH-1:0]         ch_ready;
    logic [INWIDTH-1:0]     dp_sample;
    logic [LOGNCH-1:0]      dp_bank;
    logic                   dp_load;
    logic                   dp_clr_res;
    logic                   dp_cnt_en;
    logic [LOGCOEFNUM-1:0]  dp_coef_addr;
    logic                   dp_loadres;
    logic                   out_valid;
    logic [LOGNCH-1:0]      out_ch;
    logic                   out_ready;
    logic                   busy;

    always #5 clock = ~clock;

    fir_channel_scheduler #(
        .INWIDTH    (INWIDTH),
        .NCH        (NCH),
        .LOGNCH     (LOGNCH),
        .COEFNUM    (COEFNUM),
        .LOGCOEFNUM (LOGCOEFNUM)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ch_valid     (ch_valid),
        .ch_data      (ch_data),
        .ch_ready     (ch_ready),
        .dp_sample    (dp_sample),
        .dp_bank      (dp_bank),
        .dp_load      (dp_load),
        .dp_clr_res   (dp_clr_res),
        .dp_cnt_en    (dp_cnt_en),
        .dp_coef_addr (dp_coef_addr),
        .dp_loadres   (dp_loadres),
        .out_valid    (out_valid),
        .out_ch       (out_ch),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int hs_cyc[$];
    int hs_ch[$];
    int ov_cyc[$];

    // Model: m_t = cycles since the accepted handshake (-1 when idle).
    int                 m_t   = -1;
    int                 m_ptr = 0;
    int                 m_ch  = 0;
    logic [INWIDTH-1:0] m_sample = '0;
    logic               prev_ov  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_pick(input logic [NCH-1:0] v, input int p);
        int start;
`ifdef FIR_SCHED_FIXED_PRIO_EN
        start = 0 * p;
`else
        start = p;
`endif
        for (int k = 0; k < NCH; k++)
            if (v[(start + k) % NCH]) return (start + k) % NCH;
        return -1;
    endfunction

    function automatic int q_at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    always @(negedge clock) begin
        int g;
        int idx;
        logic [NCH-1:0] exp_rdy;
        cyc++;
        if (!reset) begin
            check("rst_ch_ready", ch_ready, 0);
            check("rst_busy", busy, 0);
            check("rst_dp_load", dp_load, 0);
            check("rst_dp_clr_res", dp_clr_res, 0);
            check("rst_dp_cnt_en", dp_cnt_en, 0);
            check("rst_dp_coef_addr", dp_coef_addr, 0);
            check("rst_dp_loadres", dp_loadres, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_ch", out_ch, 0);
            check("rst_dp_bank", dp_bank, 0);
            check("rst_dp_sample", dp_sample, 0);
            m_t     = -1;
            m_ptr   = 0;
            prev_ov = 1'b0;
        end else begin
            g = (m_t < 0) ? model_pick(ch_valid, m_ptr) : -1;
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("ch_ready", ch_ready, exp_rdy);
            check("busy", busy, m_t >= 1);
            check("dp_load", dp_load, m_t == 1);
            check("dp_clr_res", dp_clr_res, m_t == 1);
            check("dp_cnt_en", dp_cnt_en, (m_t >= 2) && (m_t <= COEFNUM + 1));
            if ((m_t >= 2) && (m_t <= COEFNUM + 1))
                check("dp_coef_addr", dp_coef_addr, m_t - 2);
            check("dp_loadres", dp_loadres, m_t == COEFNUM + 2);
            check("out_valid", out_valid, m_t >= T_OUT);
            if (m_t >= 1) begin
                check("dp_sample", dp_sample, m_sample);
                check("dp_bank", dp_bank, m_ch);
                check("out_ch", out_ch, m_ch);
            end
            if ((ch_ready & ch_valid) != '0) begin
                idx = -1;
                for (int c = 0; c < NCH; c++) if (ch_ready[c]) idx = c;
                hs_cyc.push_back(cyc);
                hs_ch.push_back(idx);
            end
            if (out_valid && !prev_ov) ov_cyc.push_back(cyc);
            prev_ov = out_valid;
            if (g >= 0) begin
                m_t      = 1;
                m_ch     = g;
                m_sample = ch_data[g*INWIDTH +: INWIDTH];
                m_ptr    = (g + 1) % NCH;
            end else if (m_t >= T_OUT) begin
                if (out_ready) m_t = -1;
            end else if (m_t >= 1) begin
                m_t++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [INWIDTH-1:0] v);
        ch_data[ch*INWIDTH +: INWIDTH] = v;
    endtask

    task automatic wait_hs(input int n, input string name);
        int b = 0;
        while (hs_cyc.size() < n && b < 400) begin
            tick();
            b++;
        end
        checks++;
        if (hs_cyc.size() < n) begin
            errors++;
            $display("FAIL %s: got %0d handshakes expected %0d (timeout)", name, hs_cyc.size(), n);
        end
    endtask

    task automatic wait_idle(input string name);
        int b = 0;
        while (busy && b < 2000) begin
            tick();
            b++;
        end
        check(name, busy, 0);
    endtask

    task automatic wait_ov(input string name);
        int b = 0;
        while (!out_valid && b < 400) begin
            tick();
            b++;
        end
        check(name, out_valid, 1);
    endtask

    initial begin
        int n;
        int b;
        reset     = 1'b0;
        ch_valid  = '0;
        ch_data   = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Single request on channel 2
        set_data(2, 16'h1234);
        ch_valid = 4'b0100;
        wait_hs(1, "single_hs");
        ch_valid = '0;
        check("single_ch", q_at(hs_ch, 0), 2);
        check("single_sample", dp_sample, 16'h1234);
        check("single_bank", dp_bank, 2);
        n = 0;
        repeat (70) begin
            if (dp_cnt_en) n++;
            tick();
        end
        check("single_mac_cycles", n, 64);
        check("single_latency", q_at(ov_cyc, 0) - q_at(hs_cyc, 0), 67);
        wait_idle("single_idle");

        // Reset during MAC abandons the operation
        ch_valid = 4'b0010;
        wait_hs(2, "rst_hs");
        ch_valid = '0;
        b = 0;
        while (!(dp_cnt_en && dp_coef_addr == 30) && b < 200) begin
            tick();
            b++;
        end
        check("rst_reached_addr30", dp_coef_addr, 30);
        reset = 1'b0;
        #1;
        check("rst_immediate_busy", busy, 0);
        check("rst_immediate_cnt_en", dp_cnt_en, 0);
        repeat (2) tick();
        reset    = 1'b1;
        ch_valid = 4'b1000;
        wait_hs(3, "post_rst_hs");
        ch_valid = '0;
        check("post_rst_ch", q_at(hs_ch, 2), 3);
        check("rst_no_out_valid", ov_cyc.size(), 1);
        wait_idle("post_rst_idle");

        // All channels continuously valid
        ch_valid = '1;
        wait_hs(8, "all_hs");
        ch_valid = '0;
        for (int i = 0; i < 5; i++) begin
`ifdef FIR_SCHED_FIXED_PRIO_EN
            check("all_order", q_at(hs_ch, 3 + i), 0);
`else
            check("all_order", q_at(hs_ch, 3 + i), i % NCH);
`endif
            if (i > 0) check("all_spacing", q_at(hs_cyc, 3 + i) - q_at(hs_cyc, 2 + i), 68);
        end
        wait_idle("all_idle");

        // Backpressure: out_ready low for 10 cycles after out_valid rises
        out_ready = 1'b0;
        ch_valid  = 4'b0001;
        wait_ov("bp_ov");
        repeat (10) tick();
        out_ready = 1'b1;
        wait_hs(10, "bp_hs");
        ch_valid = '0;
        check("bp_gap", q_at(hs_cyc, 9) - q_at(hs_cyc, 8), 78);
        wait_idle("bp_idle");

        // Channel 1 pulses valid only while the datapath is busy
        ch_valid = 4'b0001;
        wait_hs(11, "wd_hs");
        ch_valid = '0;
        repeat (10) tick();
        ch_valid = 4'b0010;
        repeat (3) tick();
        ch_valid = '0;
        wait_idle("wd_idle");
        check("wd_no_grant", hs_cyc.size(), 11);

        // Pointer to 2, then channels 0 and 3 together
        ch_valid = 4'b0010;
        wait_hs(12, "sim_prep_hs");
        ch_valid = 4'b1001;
        wait_hs(14, "sim_hs");
        ch_valid = '0;
`ifdef FIR_SCHED_FIXED_PRIO_EN
        check("sim_first", q_at(hs_ch, 12), 0);
        check("sim_second", q_at(hs_ch, 13), 0);
`else
        check("sim_first", q_at(hs_ch, 12), 3);
        check("sim_second", q_at(hs_ch, 13), 0);
`endif
        wait_idle("sim_idle");

        // Randomized traffic with occasional resets
        repeat (3000) begin
            ch_valid  = NCH'($urandom);
            ch_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 499) != 0);
            tick();
        end
        reset     = 1'b1;
        ch_valid  = '0;
        out_ready = 1'b1;
        tick();
        wait_idle("final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
